// File: rtl/ray_trace_scheduler.sv
// Raster-walks a COLS x ROWS frame through the pixel tracer and writes each result to the frame buffer.
// Min 3 cycles/pixel; stalls in ISSUE until trace_ack and in WAIT until trace_done or the watchdog fires.
module ray_trace_scheduler #(
   parameter int COLS    = 128,
   parameter int ROWS    = 64,
   parameter int TIMEOUT = 1023,
   localparam int COL_W  = $clog2(COLS),
   localparam int ROW_W  = $clog2(ROWS)
) (
   input  logic             tracer_clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             continuous,
   output logic             trace_req,
   input  logic             trace_ack,
   output logic [COL_W-1:0] trace_col,
   output logic [ROW_W-1:0] trace_row,
   input  logic             trace_done,
   input  logic [11:0]      trace_color,
   input  logic             trace_hit,
   output logic [COL_W-1:0] col_addr,
   output logic [ROW_W-1:0] row_addr,
   output logic [11:0]      dout,
   output logic             wr_en,
   output logic             busy,
   output logic             frame_done,
   output logic [3:0]       collision_sig,
   output logic             timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, FRAME_END} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic [WD_W-1:0]  wdog;
   logic             hit_lat;
   logic [3:0]       acc;
   logic             last_px;

   assign last_px    = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
   assign trace_col  = col_cnt;
   assign trace_row  = row_cnt;
   assign busy       = (state != IDLE);
   assign frame_done = (state == FRAME_END);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (frame_start) state_nxt = ISSUE;
         ISSUE:     if (trace_ack) state_nxt = WAIT;
         WAIT:      if (trace_done || (wdog == WD_LAST)) state_nxt = WRITE;
         WRITE:     state_nxt = last_px ? FRAME_END : ISSUE;
         FRAME_END: state_nxt = continuous ? ISSUE : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge tracer_clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         col_cnt       <= '0;
         row_cnt       <= '0;
         wdog          <= '0;
         hit_lat       <= 1'b0;
         acc           <= '0;
         trace_req     <= 1'b0;
         wr_en         <= 1'b0;
         col_addr      <= '0;
         row_addr      <= '0;
         dout          <= '0;
         collision_sig <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         // strobes are decoded from the next state so they line up with the state they belong to
         trace_req <= (state_nxt == ISSUE);
         wr_en     <= (state_nxt == WRITE);
         case (state)
            IDLE: begin
               if (frame_start) begin
                  col_cnt     <= '0;
                  row_cnt     <= '0;
                  acc         <= '0;
                  timeout_err <= 1'b0;
               end
            end
            ISSUE: begin
               if (trace_ack) wdog <= '0;
            end
            WAIT: begin
               wdog <= wdog + 1'b1;
               if (trace_done) begin
                  dout     <= trace_color;
                  hit_lat  <= trace_hit;
                  col_addr <= col_cnt;
                  row_addr <= row_cnt;
               end else if (wdog == WD_LAST) begin
                  dout        <= 12'h000;
                  hit_lat     <= 1'b0;
                  col_addr    <= col_cnt;
                  row_addr    <= row_cnt;
                  timeout_err <= 1'b1;
               end
            end
            WRITE: begin
               if (hit_lat) begin
                  acc <= acc | {(col_cnt == '0), (col_cnt == COL_LAST), 1'b1, (row_cnt == ROW_LAST)};
               end
               if (col_cnt == COL_LAST) begin
                  col_cnt <= '0;
                  row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
               end else begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end
            FRAME_END: begin
               collision_sig <= acc;
               if (continuous) begin
                  acc         <= '0;
                  timeout_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ray_trace_scheduler.sv
// Directed bench: a reactive tracer model plus a raster-order scoreboard on the frame-buffer port.
module tb_ray_trace_scheduler;
   localparam int NPIX = 8192;
   localparam int TMO  = 1023;

   logic        tracer_clk;
   logic        rst;
   logic        frame_start;
   logic        continuous;
   logic        trace_req;
   logic        trace_ack;
   logic [6:0]  trace_col;
   logic [5:0]  trace_row;
   logic        trace_done;
   logic [11:0] trace_color;
   logic        trace_hit;
   logic [6:0]  col_addr;
   logic [5:0]  row_addr;
   logic [11:0] dout;
   logic        wr_en;
   logic        busy;
   logic        frame_done;
   logic [3:0]  collision_sig;
   logic        timeout_err;

   ray_trace_scheduler dut (
      .tracer_clk   (tracer_clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .continuous   (continuous),
      .trace_req    (trace_req),
      .trace_ack    (trace_ack),
      .trace_col    (trace_col),
      .trace_row    (trace_row),
      .trace_done   (trace_done),
      .trace_color  (trace_color),
      .trace_hit    (trace_hit),
      .col_addr     (col_addr),
      .row_addr     (row_addr),
      .dout         (dout),
      .wr_en        (wr_en),
      .busy         (busy),
      .frame_done   (frame_done),
      .collision_sig(collision_sig),
      .timeout_err  (timeout_err)
   );

   initial begin
      tracer_clk = 1'b0;
      forever #5 tracer_clk = ~tracer_clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wr = 0;
   int wr_cnt = 0;
   int fd_cnt = 0;
   int req_cnt = 0;
   logic [6:0] ec = '0;
   logic [5:0] er = '0;
   logic       hs_prev = 1'b0;
   logic       prev_req = 1'b0;
   logic       prev_ack = 1'b0;
   logic [6:0] pc = '0;
   logic [5:0] pr = '0;
   int   hit_mode = 0;
   logic idle_stray = 1'b0;
   logic dly_en = 1'b0;
   logic sup_en = 1'b0;
   logic [6:0] sup_c = '0;
   logic [5:0] sup_r = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic logic is_sup(input logic [6:0] c, input logic [5:0] r);
      return sup_en && (c == sup_c) && (r == sup_r);
   endfunction

   function automatic int ack_dly(input logic [6:0] c, input logic [5:0] r);
      return (dly_en && c == 7'd7 && r == 6'd2) ? 5 : 0;
   endfunction

   function automatic logic hit_at(input logic [6:0] c, input logic [5:0] r);
      if (hit_mode == 1) return (c == 7'd0 && r == 6'd5) || (c == 7'd127 && r == 6'd63);
      if (hit_mode == 2) return (c == 7'd10 && r == 6'd10);
      return 1'b0;
   endfunction

   task automatic step();
      logic [11:0] edat;
      int egap;
      @(negedge tracer_clk);
      cyc++;
      if (!rst) begin
         ec = '0; er = '0; wr_cnt = 0; req_cnt = 0; hs_prev = 1'b0;
         prev_req = 1'b0; prev_ack = 1'b0; trace_ack = 1'b0; trace_done = 1'b0;
      end else begin
         if (prev_req && !prev_ack) chk("req_hold", trace_req, 1);
         if (prev_req && prev_ack) chk("req_drop", trace_req, 0);
         if (trace_req) begin
            chk("trace_col", trace_col, ec);
            chk("trace_row", trace_row, er);
         end
         if (wr_en) begin
            edat = is_sup(ec, er) ? 12'h000 : {er, ec[5:0]};
            egap = 3 + ack_dly(ec, er) + (is_sup(ec, er) ? TMO : 0);
            chk("col_addr", col_addr, ec);
            chk("row_addr", row_addr, er);
            chk("dout", dout, edat);
            if (wr_cnt > 0) chk("wr_gap", cyc - last_wr, egap);
            last_wr = cyc;
            wr_cnt++;
            if (ec == 7'd127) begin ec = '0; er = er + 1'b1; end
            else ec = ec + 1'b1;
         end
         if (frame_done) begin
            fd_cnt++;
            chk("px_count", wr_cnt, NPIX);
            wr_cnt = 0;
         end
         // tracer model: result one cycle after the handshake, optional stray pulses
         trace_done = 1'b0; trace_hit = 1'b0; trace_color = '0;
         if (hs_prev && !is_sup(pc, pr)) begin
            trace_done = 1'b1; trace_color = {pr, pc[5:0]}; trace_hit = hit_at(pc, pr);
         end
         hs_prev = 1'b0;
         if (idle_stray) begin trace_done = 1'b1; trace_color = 12'hFFF; trace_hit = 1'b1; end
         if (trace_req) begin
            if (req_cnt >= ack_dly(trace_col, trace_row)) begin
               trace_ack = 1'b1; hs_prev = 1'b1; pc = trace_col; pr = trace_row; req_cnt = 0;
            end else begin
               if (req_cnt == 2) begin trace_done = 1'b1; trace_color = 12'hABC; trace_hit = 1'b1; end
               trace_ack = 1'b0;
               req_cnt++;
            end
         end else begin
            trace_ack = 1'b0;
         end
         prev_req = trace_req;
         prev_ack = trace_ack;
      end
   endtask

   task automatic wait_frame_done(input int limit);
      int n = 0;
      step();
      while (!frame_done && n < limit) begin
         step();
         n++;
      end
      chk("frame_done_seen", frame_done, 1);
   endtask

   initial begin
      int n;
      rst = 1'b0; frame_start = 1'b0; continuous = 1'b0;
      trace_ack = 1'b0; trace_done = 1'b0; trace_color = '0; trace_hit = 1'b0;
      #1;
      chk("reset_outs", {trace_req, trace_col, trace_row, col_addr, row_addr, dout, wr_en,
                         busy, frame_done, collision_sig, timeout_err}, 0);
      step(); step();
      rst = 1'b1;

      // stray trace_done while idle must not write
      idle_stray = 1'b1;
      repeat (4) begin
         step();
         chk("idle_wr", wr_en, 0);
         chk("idle_busy", busy, 0);
      end
      idle_stray = 1'b0;
      step();

      // frame A: single shot, hits at (0,5)/(127,63), ack held off 5 cycles at (7,2)
      hit_mode = 1; dly_en = 1'b1;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("a_busy", busy, 1);
      chk("a_req", trace_req, 1);
      wait_frame_done(30000);
      chk("a_tmo_err", timeout_err, 0);
      chk("a_coll_old", collision_sig, 4'b0000);
      step();
      chk("a_coll", collision_sig, 4'b1111);
      chk("a_busy_after", busy, 0);
      repeat (3) begin
         step();
         chk("a_fd_once", frame_done, 0);
      end
      chk("a_fd_cnt", fd_cnt, 1);

      // frame B: continuous, watchdog at (3,0), hit at (10,10), ignored frame_start pulses
      hit_mode = 2; dly_en = 1'b0; sup_en = 1'b1; sup_c = 7'd3; sup_r = 6'd0;
      continuous = 1'b1;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      repeat (2000) step();
      chk("b_tmo_set", timeout_err, 1);
      frame_start = 1'b1; repeat (3) step(); frame_start = 1'b0;
      chk("b_busy_mid", busy, 1);
      chk("b_coll_hold", collision_sig, 4'b1111);
      wait_frame_done(40000);
      chk("b_tmo_err", timeout_err, 1);
      chk("b_coll_hold_end", collision_sig, 4'b1111);
      sup_c = 7'd64; sup_r = 6'd20;
      step();
      chk("c_restart_req", trace_req, 1);
      chk("c_busy", busy, 1);
      chk("c_coll", collision_sig, 4'b0010);
      chk("c_tmo_clear", timeout_err, 0);

      // frame C: reset while (64,20) is waiting on the tracer
      n = 0;
      while (!(trace_req && trace_col == 7'd64 && trace_row == 6'd20) && n < 30000) begin
         step();
         n++;
      end
      chk("c_reach_64_20", trace_req && trace_col == 7'd64 && trace_row == 6'd20, 1);
      repeat (3) step();
      #2 rst = 1'b0;
      #1;
      chk("rst_async_outs", {trace_req, trace_col, trace_row, col_addr, row_addr, dout, wr_en,
                             busy, frame_done, collision_sig, timeout_err}, 0);
      repeat (3) begin
         step();
         chk("rst_no_fd", frame_done, 0);
      end
      rst = 1'b1; sup_en = 1'b0; continuous = 1'b0;
      step();
      chk("post_rst_idle", {busy, collision_sig, wr_en}, 0);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("restart_req", trace_req, 1);
      repeat (12) step();
      chk("restart_px", wr_cnt, 4);
      chk("fd_total", fd_cnt, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
